// File: rtl/rom_load_pkg.sv
// Shared types and region lookup for the ROM download sequencer.
// Supports up to 8 regions with addresses up to 32 bits wide.
package rom_load_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} load_state_t;

    localparam int MAX_REGIONS = 8;
    localparam int MAX_ADDR_W  = 32;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } region_t;

    // Unused end slots must be zero so they can never match.
    function automatic region_t region_of(
        input logic [MAX_ADDR_W-1:0]             addr,
        input logic [MAX_REGIONS*MAX_ADDR_W-1:0] ends
    );
        region_t r;
        r = '0;
        for (int i = MAX_REGIONS - 1; i >= 0; i--) begin
            if (addr < ends[i*MAX_ADDR_W +: MAX_ADDR_W]) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_load_ctrl_decode.sv
// rom_region_decode: combinational region select and region start offset
// for one ioctl address.
module rom_region_decode
    import rom_load_pkg::*;
#(
    parameter int                            NUM_REGIONS = 4,
    parameter int                            ADDR_W      = 25,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_END  = '0
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [NUM_REGIONS-1:0] sel,
    output logic [ADDR_W-1:0]      base,
    output logic                   hit
);

    logic [MAX_REGIONS*MAX_ADDR_W-1:0] ends;
    region_t                           r;

    always_comb begin
        ends = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            ends[i*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(REGION_END[i*ADDR_W +: ADDR_W]);
        end
        r    = region_of(MAX_ADDR_W'(addr), ends);
        sel  = '0;
        base = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (r.valid && r.idx == 3'(i)) sel[i] = 1'b1;
        end
        // Region i starts where region i-1 ends; region 0 starts at 0.
        for (int i = 1; i < NUM_REGIONS; i++) begin
            if (r.idx == 3'(i)) base = REGION_END[(i-1)*ADDR_W +: ADDR_W];
        end
        hit = r.valid;
    end

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download sequencer and core-reset generator for arcade top levels.
// Define ROM_LOAD_CHECKSUM_EN to add the 16-bit byte-sum check and sum_out.
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter int                            NUM_REGIONS = 4,
    parameter int                            ADDR_W      = 25,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_END  = {NUM_REGIONS{ADDR_W'(0)}},
    parameter logic [7:0]                    ROM_INDEX   = 8'd0,
    parameter int                            RESET_HOLD  = 16
`ifdef ROM_LOAD_CHECKSUM_EN
    ,
    parameter logic [15:0]                   EXPECTED_SUM = 16'h0000
`endif
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [ADDR_W-1:0]      ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    input  logic                   user_reset,
    output logic [NUM_REGIONS-1:0] rom_wr,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic [7:0]             rom_data,
    output logic                   rom_loaded,
    output logic                   core_reset,
    output logic                   load_error
`ifdef ROM_LOAD_CHECKSUM_EN
    ,
    output logic [15:0]            sum_out
`endif
);

    localparam logic [ADDR_W-1:0] LOAD_SIZE = REGION_END[NUM_REGIONS*ADDR_W-1 -: ADDR_W];
    localparam int                HOLD_W    = $clog2(RESET_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD);

    load_state_t             state;
    logic                    dl_q;
    logic [ADDR_W-1:0]       byte_cnt;
    logic                    overrun;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [NUM_REGIONS-1:0]  dec_sel;
    logic [ADDR_W-1:0]       dec_base;
    logic                    dec_hit;
    logic                    start;
    logic                    fall;
    logic                    wr_ok;
    logic                    load_ok;
    logic [ADDR_W-1:0]       cnt_next;
    logic                    over_next;
`ifdef ROM_LOAD_CHECKSUM_EN
    logic [15:0]             sum_next;
`endif

    rom_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .REGION_END  (REGION_END)
    ) u_decode (
        .addr (ioctl_addr),
        .sel  (dec_sel),
        .base (dec_base),
        .hit  (dec_hit)
    );

    // ioctl_wr is a fire-and-forget strobe: no backpressure, every byte is
    // taken in the cycle it is offered. A write in the same cycle as the
    // download fall still counts toward the length check.
    always_comb begin
        start     = ioctl_download && !dl_q && (ioctl_index == ROM_INDEX) && (state != LOAD);
        fall      = (state == LOAD) && !ioctl_download;
        wr_ok     = (state == LOAD) && ioctl_wr && dec_hit;
        cnt_next  = (wr_ok && byte_cnt != '1) ? byte_cnt + ADDR_W'(1) : byte_cnt;
        over_next = overrun || ((state == LOAD) && ioctl_wr && !dec_hit);
        load_ok   = (cnt_next == LOAD_SIZE) && !over_next;
`ifdef ROM_LOAD_CHECKSUM_EN
        sum_next  = wr_ok ? sum_out + 16'(ioctl_dout) : sum_out;
        load_ok   = load_ok && (sum_next == EXPECTED_SUM);
`endif
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            rom_wr     <= '0;
            rom_addr   <= '0;
            rom_data   <= '0;
            rom_loaded <= 1'b0;
            load_error <= 1'b0;
            core_reset <= 1'b1;
            hold_cnt   <= '0;
            byte_cnt   <= '0;
            overrun    <= 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
            sum_out    <= '0;
`endif
        end else begin
            dl_q   <= ioctl_download;
            rom_wr <= wr_ok ? dec_sel : '0;
            if (wr_ok) begin
                rom_addr <= ioctl_addr - dec_base;
                rom_data <= ioctl_dout;
            end
            // A new download outranks user_reset and any pending hold.
            if (start) begin
                state      <= LOAD;
                core_reset <= 1'b1;
                rom_loaded <= 1'b0;
                load_error <= 1'b0;
                byte_cnt   <= '0;
                overrun    <= 1'b0;
`ifdef ROM_LOAD_CHECKSUM_EN
                sum_out    <= '0;
`endif
            end else begin
                case (state)
                    LOAD: begin
                        byte_cnt <= cnt_next;
                        overrun  <= over_next;
`ifdef ROM_LOAD_CHECKSUM_EN
                        sum_out  <= sum_next;
`endif
                        if (fall) begin
                            if (load_ok) begin
                                state      <= HOLD;
                                rom_loaded <= 1'b1;
                                hold_cnt   <= HOLD_LOAD;
                            end else begin
                                state      <= ERR;
                                load_error <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (user_reset) begin
                            hold_cnt <= HOLD_LOAD;
                        end else if (hold_cnt == HOLD_W'(1) || hold_cnt == '0) begin
                            state      <= RUN;
                            core_reset <= 1'b0;
                            hold_cnt   <= '0;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                    RUN: begin
                        if (user_reset) begin
                            state      <= HOLD;
                            core_reset <= 1'b1;
                            hold_cnt   <= HOLD_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: two regions {0x4000, 0x6000}, 16-cycle hold,
// reference model compared every cycle plus hand-computed spot checks.
module tb_rom_load_ctrl;

    localparam int HOLD = 16;
    localparam int TOP  = 32'h6000;
    localparam int REG_END [2]   = '{32'h4000, 32'h6000};
    localparam int REG_START [2] = '{32'h0000, 32'h4000};

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [15:0] ioctl_addr = 16'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        user_reset = 1'b0;
    logic [1:0]  rom_wr;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_loaded;
    logic        core_reset;
    logic        load_error;
`ifdef ROM_LOAD_CHECKSUM_EN
    logic [15:0] sum_out;
`endif

    rom_load_ctrl #(
        .NUM_REGIONS (2),
        .ADDR_W      (16),
        .REGION_END  ({16'h6000, 16'h4000}),
        .ROM_INDEX   (8'd0),
        .RESET_HOLD  (HOLD)
`ifdef ROM_LOAD_CHECKSUM_EN
        ,
        .EXPECTED_SUM (16'hD000)
`endif
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .user_reset     (user_reset),
        .rom_wr         (rom_wr),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_loaded     (rom_loaded),
        .core_reset     (core_reset),
        .load_error     (load_error)
`ifdef ROM_LOAD_CHECKSUM_EN
        ,
        .sum_out        (sum_out)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk_sys = ~clk_sys;

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Behaviour in terms of events: a good load releases the core HOLD
    // cycles after the download ends or after the latest user_reset.
    bit          model_valid = 1'b0;
    longint      cyc = 0;
    longint      m_release = 0;
    bit          m_loading = 1'b0, m_loaded = 1'b0, m_error = 1'b0;
    bit          m_dl_prev = 1'b0, m_over = 1'b0, m_sum_ok;
    int          m_cnt = 0;
    logic [15:0] m_sum = '0;
    logic [1:0]  exp_wr = '0;
    logic [15:0] exp_addr = '0;
    logic [7:0]  exp_data = '0;
    bit          exp_core = 1'b1;

    always @(posedge clk_sys) begin
        int a;
        int ri;
        cyc++;
        if (reset) begin
            m_loading = 0; m_loaded = 0; m_error = 0; m_dl_prev = 0;
            m_over = 0; m_cnt = 0; m_sum = '0;
            exp_wr = '0; exp_addr = '0; exp_data = '0; exp_core = 1'b1;
            model_valid = 1'b1;
        end else begin
            exp_wr = '0;
            if (m_loading && ioctl_wr) begin
                a = ioctl_addr;
                if (a < TOP) begin
                    ri = (a < REG_END[0]) ? 0 : 1;
                    exp_wr[ri] = 1'b1;
                    exp_addr   = 16'(a - REG_START[ri]);
                    exp_data   = ioctl_dout;
                    if (m_cnt < 65535) m_cnt++;
                    m_sum = m_sum + {8'd0, ioctl_dout};
                end else begin
                    m_over = 1'b1;
                end
            end
`ifdef ROM_LOAD_CHECKSUM_EN
            m_sum_ok = (m_sum == 16'hD000);
`else
            m_sum_ok = 1'b1;
`endif
            if (m_loading && !ioctl_download) begin
                m_loading = 0;
                if (m_cnt == TOP && !m_over && m_sum_ok) begin
                    m_loaded  = 1;
                    m_release = cyc + HOLD;
                end else begin
                    m_error = 1;
                end
            end else if (!m_loading && ioctl_download && ioctl_index == 8'd0 && !m_dl_prev) begin
                m_loading = 1; m_loaded = 0; m_error = 0;
                m_cnt = 0; m_over = 0; m_sum = '0;
            end else if (user_reset && m_loaded) begin
                m_release = cyc + HOLD;
            end
            m_dl_prev = ioctl_download;
            exp_core  = !(m_loaded && !m_loading && cyc >= m_release);
        end
    end

    // Single compare process: outputs are stable at the falling edge.
    always @(negedge clk_sys) begin
        if (model_valid) begin
            check("cycle_outputs",
                  {rom_wr, rom_addr, rom_data, rom_loaded, core_reset, load_error},
                  {exp_wr, exp_addr, exp_data, m_loaded, exp_core, m_error});
`ifdef ROM_LOAD_CHECKSUM_EN
            check("sum_out", sum_out, m_sum);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    // Sequential download of n bytes (data = low address byte); the last
    // write coincides with the fall of ioctl_download.
    task automatic run_load(input int n_bytes, input bit bad_write, input bit pin);
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b0;
        @(negedge clk_sys);
        for (int a = 0; a < n_bytes; a++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = a[15:0];
            ioctl_dout = a[7:0];
            if (a == n_bytes - 1) ioctl_download = 1'b0;
            @(negedge clk_sys);
            if (pin && a == 32'h1234)
                check("region0_write", {rom_wr, rom_addr, rom_data}, {2'b01, 16'h1234, 8'h34});
            if (pin && a == 32'h4000)
                check("region1_first", {rom_wr, rom_addr, rom_data}, {2'b10, 16'h0000, 8'h00});
            if (pin && a == 32'h5AB0)
                check("region1_write", {rom_wr, rom_addr, rom_data}, {2'b10, 16'h1AB0, 8'hB0});
            if (bad_write && a == 100) begin
                ioctl_addr = 16'h6000;
                ioctl_dout = 8'hEE;
                @(negedge clk_sys);
                check("overrun_no_strobe", rom_wr, 2'b00);
                check("error_cleared_in_load", load_error, 1'b0);
            end
        end
        ioctl_wr = 1'b0;
    endtask

    task automatic count_high(input int budget, output int hi);
        hi = 0;
        while (core_reset === 1'b1 && hi < budget) begin
            hi++;
            @(negedge clk_sys);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int hi;
        int hi2;
        repeat (3) @(negedge clk_sys);
        check("reset_state", {rom_wr, rom_addr, rom_data, rom_loaded, core_reset, load_error},
              {2'b00, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0});
        reset = 1'b0;
        @(negedge clk_sys);

        // Short download: one byte missing.
        run_load(32'h5FFF, 1'b0, 1'b0);
        check("short_load_error", {rom_loaded, load_error}, 2'b01);
        hi = 0;
        for (int k = 0; k < 1000; k++) begin
            user_reset = (k == 500);
            if (core_reset === 1'b1) hi++;
            @(negedge clk_sys);
        end
        user_reset = 1'b0;
        check("err_hold_1000", hi, 1000);

        // Full length but one write past the last region.
        run_load(32'h6000, 1'b1, 1'b0);
        check("overrun_error", {rom_loaded, load_error}, 2'b01);
        repeat (4) @(negedge clk_sys);

        // Good download.
        run_load(32'h6000, 1'b0, 1'b1);
        check("full_loaded", {rom_loaded, load_error}, 2'b10);
        count_high(200, hi);
        check("hold_after_load", hi, 16);
        repeat (3) @(negedge clk_sys);
        check("run_core_reset", core_reset, 1'b0);

        // One-cycle user reset in RUN.
        user_reset = 1'b1;
        @(negedge clk_sys);
        user_reset = 1'b0;
        count_high(200, hi);
        check("user_reset_pulse", hi, 16);

        // user_reset held: one cycle to enter HOLD, five more inside HOLD.
        hi = 0;
        user_reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_sys);
            if (k < 5 && core_reset === 1'b1) hi++;
        end
        user_reset = 1'b0;
        count_high(200, hi2);
        check("user_reset_held", hi + hi2, 21);
        repeat (3) @(negedge clk_sys);

        // Foreign index download in RUN is ignored.
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        for (int a = 0; a < 4; a++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = a[15:0];
            ioctl_dout = 8'h77;
            @(negedge clk_sys);
        end
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("foreign_index_ignored", {rom_wr, rom_loaded, core_reset}, {2'b00, 1'b1, 1'b0});
        ioctl_index = 8'd0;
        @(negedge clk_sys);

        // Reset asserted in the middle of a ROM download.
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        for (int a = 0; a < 3; a++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = a[15:0];
            ioctl_dout = 8'hA0;
            @(negedge clk_sys);
        end
        check("write_before_reset", {rom_wr, rom_addr, rom_data}, {2'b01, 16'h0002, 8'hA0});
        reset = 1'b1;
        @(negedge clk_sys);
        check("reset_mid_load", {rom_wr, rom_addr, rom_data, rom_loaded, core_reset, load_error},
              {2'b00, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0});
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog: the directed sequence needs well under 100k cycles.
    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: sequence still running at t=%0t, required to finish earlier", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
Parametrised ROM-download sequencer and core-reset generator for arcade top levels. It replaces the ad-hoc "rom_loaded / reset" register pattern used in each top level. It takes the data_io download stream, splits it into NUM_REGIONS contiguous ROM regions with region-local addresses and one-hot write strobes, and validates the download length. It drives the core reset with a guaranteed minimum hold time and supports user-reset requests.

Parameters:
- NUM_REGIONS, 4, number of ROM regions; range 1..8.
- ADDR_W, 25, width of the ioctl address and of region-local addresses.
- REGION_END, {NUM_REGIONS{ADDR_W'(0)}}, packed array of exclusive end addresses; region i covers [REGION_END[i-1], REGION_END[i]), and region 0 starts at 0. Values must be strictly increasing.
- ROM_INDEX, 8'd0, the ioctl_index value that identifies a ROM download.
- RESET_HOLD, 16, minimum number of clk_sys cycles core_reset stays high after a load or a user reset; must be ≥1.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  download in progress (from data_io)
- ioctl_index  in  8  download index
- ioctl_wr  in  1  byte-write strobe, one cycle per byte
- ioctl_addr  in  ADDR_W  byte address
- ioctl_dout  in  8  byte data
- user_reset  in  1  OR of status[0] and the reset button
- rom_wr  out  NUM_REGIONS  one-hot region write strobe
- rom_addr  out  ADDR_W  region-local address (ioctl_addr minus region start)
- rom_data  out  8  registered ioctl_dout
- rom_loaded  out  1  a valid image has been loaded
- core_reset  out  1  reset to the game core
- load_error  out  1  the last download was short or went out of range

Behaviour:
- One clock (clk_sys). Reset is synchronous and active-high. The state register and all outputs are registered.
- States: IDLE, LOAD, HOLD, RUN, ERR.
- Values while reset is asserted:
  - state = IDLE
  - rom_wr = 0, rom_addr = 0, rom_data = 0
  - rom_loaded = 0, load_error = 0
  - core_reset = 1, hold counter = 0
- A download is accepted only when ioctl_download=1 and ioctl_index==ROM_INDEX. Downloads with any other index are ignored entirely: no strobes and no state change.
- IDLE: core_reset=1. On an accepted download going high, enter LOAD.
- LOAD: core_reset=1. On entry, clear rom_loaded, load_error, the byte counter and the overrun flag.
  - Each ioctl_wr with addr < REGION_END[N-1] gives, exactly 1 cycle later:
    - rom_wr[i]=1 for the matching region i, lasting 1 cycle;
    - rom_addr = addr - start_i;
    - rom_data = ioctl_dout.
  - Each such write increments the byte counter, which saturates at 2^ADDR_W-1.
  - A write with addr ≥ REGION_END[N-1] produces no strobe and sets overrun.
  - A write and the fall of ioctl_download in the same cycle: the write is still issued.
- On the fall of ioctl_download in LOAD:
  - If byte counter == REGION_END[N-1] and no overrun (plus the checksum condition when enabled): go to HOLD, set rom_loaded=1, and load the hold counter with RESET_HOLD.
  - Otherwise: go to ERR and set load_error=1.
- HOLD: core_reset=1. The counter decrements each cycle. Transition to RUN on the cycle the counter reaches 0, so core_reset is high for exactly RESET_HOLD cycles in HOLD.
  - user_reset=1 in HOLD reloads the counter.
- RUN: core_reset=0.
  - user_reset=1 goes to HOLD and reloads the counter; core_reset rises on the next cycle.
- ERR: core_reset=1 and load_error=1. user_reset is ignored. Only a new accepted download (to LOAD) leaves ERR.
- An accepted download starting in HOLD or RUN goes to LOAD; core_reset=1 from the next cycle.
- Simultaneous events: download start and user_reset in the same cycle → the download wins.
- Internal edge detection uses a registered copy of ioctl_download. That register is cleared by reset, so a download already high when reset releases is treated as a new start.

Optional Feature:
- ROM_LOAD_CHECKSUM_EN adds a parameter EXPECTED_SUM (16-bit, default 0) and an output sum_out[15:0].
- When defined:
  - A running 16-bit wrap-around sum of every accepted byte is kept; it is cleared on LOAD entry.
  - sum_out shows the live value.
  - A mismatch with EXPECTED_SUM at download end routes to ERR.
- When undefined: no adder, no port, and the success condition is the length and overrun check only.

Decomposition:
- Package rom_load_pkg holds:
  - typedef enum logic [2:0] load_state_t {IDLE, LOAD, HOLD, RUN, ERR};
  - the function region_of(addr, ends), returning the region index and a valid flag.
- Natural sub-module: rom_region_decode, a combinational comparator chain giving one-hot region select and start offset. It is instanced once, and its output is registered in rom_load_ctrl.

Test Plan:
- NUM_REGIONS=2, REGION_END={16'h6000, 16'h4000}: download 0x6000 sequential bytes → rom_wr[0] for addresses 0..0x3FFF, rom_wr[1] with rom_addr 0..0x1FFF, each 1 cycle after ioctl_wr. rom_loaded=1, core_reset high 16 cycles after the download falls, then 0.
- Short download of 0x5FFF bytes → ERR, load_error=1, core_reset held high for 1000 cycles; a following full download clears load_error and reaches RUN.
- Write to addr 0x6000 during the load → no strobe, ERR at download end.
- In RUN, pulse user_reset for 1 cycle → core_reset=1 the next cycle for 16 cycles. user_reset held high in HOLD for 5 cycles extends the hold to 5+16 cycles.
- Download with ioctl_index=1 in RUN → no rom_wr, core_reset stays 0. Index 0 with reset asserted mid-LOAD → outputs return to reset values the next cycle.
- With ROM_LOAD_CHECKSUM_EN, EXPECTED_SUM=0x1234: bytes summing to 0x1234 → RUN; a single corrupted byte → ERR with sum_out ≠ 0x1234.
